// File: rtl/dpram_copy_engine_pkg.sv
// Shared types and defaults for the dual-port RAM copy/fill engine.
package dpram_copy_engine_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 13;

  localparam logic EN  = 1'b1;
  localparam logic DIS = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef enum logic {
    OP_COPY = 1'b0,
    OP_FILL = 1'b1
  } op_e;

endpackage

// File: rtl/dpram_copy_engine_if.sv
// Command interface plus both RAM ports as seen by the copy engine.
interface dpram_copy_engine_if
  import dpram_copy_engine_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
);

  logic              start;
  logic              op;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] fill_data;
  logic              abort;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [LEN_W-1:0]  count;

  logic [ADDR_W-1:0] addra;
  logic              wea;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;
  logic [ADDR_W-1:0] addrb;
  logic              web;
  logic [DATA_W-1:0] dinb;

  modport master (
    input  start, op, src_addr, dst_addr, len, fill_data, abort, douta,
    output busy, done, aborted, count, addra, wea, dina, addrb, web, dinb
  );

  modport slave (
    output start, op, src_addr, dst_addr, len, fill_data, abort, douta,
    input  busy, done, aborted, count, addra, wea, dina, addrb, web, dinb
  );

endinterface

// File: rtl/dpram_copy_engine_agen.sv
// Read/write address counters with remaining-count and terminal-count detect.
module dpram_copy_engine_agen
  import dpram_copy_engine_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              wr_done_o
);

  localparam logic [LEN_W-1:0]  CNT_ONE  = LEN_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] wr_next_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [LEN_W-1:0]  rd_left_q;
  logic [LEN_W-1:0]  wr_left_q;

  // The first read address goes out at load, so only len-1 further reads are
  // issued; writes lag one edge behind and need all len steps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_addr_q <= '0;
      wr_next_q <= '0;
      wr_addr_q <= '0;
      rd_left_q <= '0;
      wr_left_q <= '0;
    end else if (load_i) begin
      rd_addr_q <= src_i;
      rd_left_q <= len_i - CNT_ONE;
      wr_next_q <= dst_i;
      wr_left_q <= len_i;
    end else if (step_i) begin
      if (rd_left_q != '0) begin
        rd_addr_q <= rd_addr_q + ADDR_ONE;
        rd_left_q <= rd_left_q - CNT_ONE;
      end
      if (wr_left_q != '0) begin
        wr_addr_q <= wr_next_q;
        wr_next_q <= wr_next_q + ADDR_ONE;
        wr_left_q <= wr_left_q - CNT_ONE;
      end
    end
  end

  assign rd_addr_o = rd_addr_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_done_o = (wr_left_q == '0);

endmodule

// File: rtl/dpram_copy_engine.sv
// Block copy / fill initiator: reads RAM port A, writes RAM port B, one word per cycle.
module dpram_copy_engine
  import dpram_copy_engine_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input logic                clk,
  input logic                reset,
  dpram_copy_engine_if.master bus
);

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  state_e            state_q;
  op_e               op_q;
  logic [DATA_W-1:0] fill_q;
  logic              busy_q;
  logic              done_q;
  logic              aborted_q;
  logic              web_q;
  logic [LEN_W-1:0]  count_q;

  logic              accept;
  logic              step;
  logic              wr_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  assign accept = (state_q == ST_IDLE) && bus.start && (bus.len != '0);
  assign step   = (state_q == ST_RUN) && !bus.abort && !wr_done;

  dpram_copy_engine_agen #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_agen (
    .clk_i    (clk),
    .rst_ni   (reset),
    .load_i   (accept),
    .step_i   (step),
    .src_i    (bus.src_addr),
    .dst_i    (bus.dst_addr),
    .len_i    (bus.len),
    .rd_addr_o(rd_addr),
    .wr_addr_o(wr_addr),
    .wr_done_o(wr_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_COPY;
      fill_q    <= '0;
      busy_q    <= DIS;
      done_q    <= DIS;
      aborted_q <= DIS;
      web_q     <= DIS;
      count_q   <= '0;
    end else begin
      done_q    <= DIS;
      aborted_q <= DIS;
      if (web_q) begin
        count_q <= count_q + CNT_ONE;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            count_q <= '0;
            if (bus.len != '0) begin
              op_q    <= op_e'(bus.op);
              fill_q  <= bus.fill_data;
              busy_q  <= EN;
              state_q <= ST_RUN;
            end else begin
              done_q  <= EN;
              state_q <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          // The write already on port B commits at this edge regardless of abort.
          if (bus.abort || wr_done) begin
            web_q     <= DIS;
            busy_q    <= DIS;
            done_q    <= EN;
            aborted_q <= bus.abort;
            state_q   <= ST_DONE;
          end else begin
            web_q <= EN;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.aborted = aborted_q;
  assign bus.count   = count_q;
  assign bus.addra   = rd_addr;
  assign bus.wea     = DIS;
  assign bus.dina    = '0;
  assign bus.addrb   = wr_addr;
  assign bus.web     = web_q;
  assign bus.dinb    = (op_q == OP_FILL) ? fill_q : bus.douta;

endmodule

// File: tb/tb_dpram_copy_engine.sv
// Randomised bench for dpram_copy_engine against a sequential-copy reference model.
module tb_dpram_copy_engine;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int LW    = 13;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic reset;

  dpram_copy_engine_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  dpram_copy_engine #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bench-side dual-port RAM with write-to-read forwarding on equal addresses.
  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] douta_q;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.web) ram[bus.addrb] <= bus.dinb;
    if (bus.web && bus.addrb == bus.addra) douta_q <= bus.dinb;
    else douta_q <= ram[bus.addra];
  end
  assign bus.douta = douta_q;

  // Reference bookkeeping: edges since acceptance and the terminating edge.
  logic          m_cmd, m_null, m_ab, m_fill;
  int unsigned   m_k, m_T, m_L;
  logic [AW-1:0] m_src, m_dst;
  logic [DW-1:0] m_fd;
  logic          p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cmd  <= 1'b0;
      m_null <= 1'b0;
      m_ab   <= 1'b0;
      m_k    <= 0;
    end else begin
      if (pre_we) ref_mem[pre_addr] <= pre_data;
      else if (p_we) ref_mem[p_addr] <= p_data;
      if (m_cmd && m_k < m_T) begin
        m_k <= m_k + 1;
        if (bus.abort) begin
          m_T  <= m_k + 1;
          m_ab <= 1'b1;
        end
      end else if (m_cmd) begin
        m_cmd <= 1'b0;
      end else if (m_null) begin
        m_null <= 1'b0;
      end else if (bus.start) begin
        if (bus.len != '0) begin
          m_cmd  <= 1'b1;
          m_k    <= 0;
          m_L    <= bus.len;
          m_T    <= bus.len + 1;
          m_ab   <= 1'b0;
          m_src  <= bus.src_addr;
          m_dst  <= bus.dst_addr;
          m_fill <= bus.op;
          m_fd   <= bus.fill_data;
        end else begin
          m_null <= 1'b1;
        end
      end
    end
  end

  int unsigned   n_tests;
  int unsigned   n_fail;
  logic          e_busy, e_done, e_ab, e_web;
  logic [LW-1:0] e_cnt;
  logic [AW-1:0] e_addra, e_addrb;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned umin(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  task automatic check_cycle();
    int unsigned   c;
    logic [DW-1:0] wd;
    p_we = 1'b0;
    c    = m_k;
    if (!reset) begin
      {e_busy, e_done, e_ab, e_web} = '0;
      e_cnt = '0; e_addra = '0; e_addrb = '0;
    end else if (m_null) begin
      {e_busy, e_done, e_ab, e_web} = 4'b0100;
      e_cnt = '0;
    end else if (m_cmd && c < m_T) begin
      e_busy = 1'b1; e_done = 1'b0; e_ab = 1'b0; e_web = (c >= 1);
      e_cnt   = LW'((c >= 1) ? c - 1 : 0);
      e_addra = m_src + AW'(umin(c, m_L - 1));
      if (c >= 1) e_addrb = m_dst + AW'(c - 1);
    end else if (m_cmd) begin
      e_busy = 1'b0; e_done = 1'b1; e_ab = m_ab; e_web = 1'b0;
      e_cnt   = LW'(m_T - 1);
      e_addra = m_src + AW'(umin(m_T - 1, m_L - 1));
      if (m_T >= 2) e_addrb = m_dst + AW'(m_T - 2);
    end else begin
      {e_busy, e_done, e_ab, e_web} = '0;
    end
    chk("busy", bus.busy, e_busy);
    chk("done", bus.done, e_done);
    chk("aborted", bus.aborted, e_ab);
    chk("web", bus.web, e_web);
    chk("count", bus.count, e_cnt);
    chk("addra", bus.addra, e_addra);
    chk("addrb", bus.addrb, e_addrb);
    chk("wea", bus.wea, 1'b0);
    chk("dina", bus.dina, '0);
    if (e_web) begin
      wd = m_fill ? m_fd : ref_mem[m_src + AW'(c - 1)];
      chk("dinb", bus.dinb, wd);
      p_we = 1'b1; p_addr = e_addrb; p_data = wd;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic mem_sync(input string nm);
    int unsigned diffs = 0;
    for (int unsigned a = 0; a < DEPTH; a++) if (ram[a] !== ref_mem[a]) diffs++;
    chk(nm, diffs, 0);
  endtask

  task automatic run_cmd(input logic op, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input logic [LW-1:0] len, input logic [DW-1:0] fd,
                         input int unsigned abort_at, input bit noise,
                         output int unsigned edges, output int unsigned busy_cyc,
                         output logic ab_seen, output logic [LW-1:0] cnt_seen);
    bus.start = 1'b1; bus.op = op; bus.src_addr = src; bus.dst_addr = dst;
    bus.len = len; bus.fill_data = fd; bus.abort = 1'b0;
    tick();
    bus.start = 1'b0; bus.src_addr = AW'($urandom); bus.dst_addr = AW'($urandom);
    bus.fill_data = $urandom; bus.len = LW'($urandom);
    edges = 0; busy_cyc = 0;
    while (!bus.done && edges < 6000) begin
      if (bus.busy) busy_cyc++;
      bus.abort = (abort_at != 0) && (edges + 1 == abort_at);
      if (noise) begin
        bus.start = 1'($urandom_range(0, 1)); bus.op = 1'($urandom_range(0, 1));
        bus.len = LW'($urandom_range(0, 64)); bus.src_addr = AW'($urandom);
      end
      tick();
      edges++;
    end
    if (!bus.done) chk("done_timeout", 1'b0, 1'b1);
    ab_seen  = bus.aborted;
    cnt_seen = bus.count;
    bus.start = 1'b0; bus.abort = 1'b0;
    tick();
  endtask

  int unsigned   edges, bcyc, ab_at;
  logic          ab;
  logic [LW-1:0] cnt, len;
  logic [AW-1:0] a, src, dst;

  initial begin
    n_tests = 0; n_fail = 0; p_we = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    reset = 1'b0;
    bus.start = 1'b0; bus.op = 1'b0; bus.src_addr = '0; bus.dst_addr = '0;
    bus.len = '0; bus.fill_data = '0; bus.abort = 1'b0;
    repeat (3) tick();
    chk("reset_count", bus.count, 0);
    reset = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) preload(AW'(i), $urandom);

    // Abort in idle is ignored.
    bus.abort = 1'b1; repeat (2) tick(); bus.abort = 1'b0;

    // Copy with stray starts while busy.
    for (int unsigned i = 0; i < 8; i++) preload(AW'(12'h100 + i), DW'(32'hA0 + i));
    run_cmd(1'b0, 12'h100, 12'h200, 13'd8, '0, 0, 1'b1, edges, bcyc, ab, cnt);
    chk("copy_edges", edges, 9);
    chk("copy_busy", bcyc, 9);
    chk("copy_count", cnt, 8);
    chk("copy_ab", ab, 0);
    for (int unsigned i = 0; i < 8; i++) begin
      a = AW'(12'h200 + i);
      chk("copy_data", ram[a], 32'hA0 + i);
    end

    // Fill across the address wrap.
    preload(12'h002, 32'h12345678);
    run_cmd(1'b1, 12'h700, 12'hFFE, 13'd4, 32'hDEADBEEF, 0, 1'b0, edges, bcyc, ab, cnt);
    chk("fill_edges", edges, 5);
    chk("fill_count", cnt, 4);
    chk("fill_ffe", ram[12'hFFE], 32'hDEADBEEF);
    chk("fill_fff", ram[12'hFFF], 32'hDEADBEEF);
    chk("fill_000", ram[12'h000], 32'hDEADBEEF);
    chk("fill_001", ram[12'h001], 32'hDEADBEEF);
    chk("fill_002", ram[12'h002], 32'h12345678);

    // Overlapping copy, distance 1.
    preload(12'h010, 32'h11); preload(12'h011, 32'h22);
    run_cmd(1'b0, 12'h010, 12'h011, 13'd4, '0, 0, 1'b0, edges, bcyc, ab, cnt);
    for (int unsigned i = 1; i <= 4; i++) begin
      a = AW'(12'h010 + i);
      chk("overlap_data", ram[a], 32'h11);
    end

    // Abort at E5.
    preload(12'h404, 32'h0BAD0404);
    run_cmd(1'b0, 12'h300, 12'h400, 13'd100, '0, 5, 1'b0, edges, bcyc, ab, cnt);
    chk("abort_edges", edges, 5);
    chk("abort_flag", ab, 1);
    chk("abort_count", cnt, 4);
    chk("abort_untouched", ram[12'h404], 32'h0BAD0404);

    // Null command.
    run_cmd(1'b0, 12'h123, 12'h456, 13'd0, '0, 0, 1'b0, edges, bcyc, ab, cnt);
    chk("null_edges", edges, 0);
    chk("null_count", cnt, 0);
    chk("null_busy", bcyc, 0);
    mem_sync("mem_directed");

    // Reset in the middle of a command.
    bus.start = 1'b1; bus.op = 1'b0; bus.src_addr = 12'h500; bus.dst_addr = 12'h600; bus.len = 13'd16;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_web", bus.web, 0);
    reset = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_no_done", bus.done, 0);
    end
    run_cmd(1'b0, 12'h500, 12'h700, 13'd5, '0, 0, 1'b0, edges, bcyc, ab, cnt);
    chk("rst_after_edges", edges, 6);
    chk("rst_after_count", cnt, 5);
    mem_sync("mem_reset");

    // Randomised commands, biased toward wrap and short overlap distances.
    for (int unsigned i = 0; i < 40; i++) begin
      src = (i % 4 == 0) ? AW'(12'hFF0 + $urandom_range(0, 15)) : AW'($urandom);
      dst = (i % 5 == 1) ? src + AW'($urandom_range(1, 3)) : AW'($urandom);
      len = ($urandom_range(0, 9) == 0) ? '0 : LW'($urandom_range(1, 48));
      ab_at = ($urandom_range(0, 3) == 0 && len != 0) ? $urandom_range(1, int'(len)) : 0;
      run_cmd(1'($urandom_range(0, 1)), src, dst, len, $urandom, ab_at, 1'b1, edges, bcyc, ab, cnt);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Full-size copy.
    run_cmd(1'b0, AW'($urandom), AW'($urandom), 13'd4096, '0, 0, 1'b0, edges, bcyc, ab, cnt);
    chk("full_count", cnt, 4096);
    chk("full_edges", edges, 4097);
    mem_sync("mem_final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dpram_copy_engine.md
Name: dpram_copy_engine

Overview:
- Initiator that drives both ports of the 4096x32 dual-port RAM: port A reads, port B writes.
- Performs block copy (RAM to RAM) or block fill (constant to RAM) at one word per cycle.
- Controlled by a start/busy/done command interface from the CPU-side controller.
- Sits between the control bus slave and the shared dual-port RAM, as the requesting end of that RAM's port protocol.

Parameters:
- ADDR_W, 12, RAM word-address width; all address arithmetic is modulo 2^ADDR_W.
- DATA_W, 32, RAM data width.
- LEN_W, 13, length/count width; holds 0..4096.

Ports:
- clk  in  1  single clock for the block and both RAM ports.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only when busy=0.
- op  in  1  0 = copy, 1 = fill.
- src_addr  in  ADDR_W  copy source base address.
- dst_addr  in  ADDR_W  destination base address.
- len  in  LEN_W  word count, 0..4096.
- fill_data  in  DATA_W  fill value; latched at start.
- abort  in  1  stop the running command.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  with done: the command ended by abort.
- count  out  LEN_W  words committed by the current/last command.
- addra  out  ADDR_W  RAM port A address.
- wea  out  1  RAM port A write enable; tied 0.
- dina  out  DATA_W  RAM port A write data; tied 0.
- douta  in  DATA_W  RAM port A read data; 1-cycle registered latency.
- addrb  out  ADDR_W  RAM port B address.
- web  out  1  RAM port B write enable.
- dinb  out  DATA_W  RAM port B write data.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; busy=0, done=0, aborted=0, count=0, addra=0, addrb=0, web=0, wea=0, dina=0.
- States: IDLE, RUN, DONE.
  - DONE lasts exactly one cycle with done=1, then the block returns to IDLE.
- Command acceptance: edge E0 with start=1, busy=0 and len!=0:
  - latch op, src, dst, len and fill_data;
  - busy<=1, count<=0, addra<=src_addr, enter RUN.
- Null command: start with len=0 -> busy stays 0; done=1 and aborted=0 for the cycle after E0; count<=0.
- start while busy is ignored; command inputs are don't-care after E0.
- Pipeline in RUN, with Ek = k-th edge after E0:
  - at Ek (k=1..len-1): addra<=src+k;
  - at Ek (k=1..len): addrb<=dst+k-1 and web<=1.
  - Write k-1 therefore commits at E(k+1).
- dinb is combinational:
  - copy mode: dinb=douta;
  - fill mode: dinb=latched fill_data.
  - In fill mode addra still sweeps; harmless.
- Completion: at E(len+1), web<=0, busy<=0, done<=1, state DONE.
  - Total latency: len+1 cycles from E0 to done.
- count increments at every edge where web=1. After normal completion count=len; count holds until the next accepted start.
- Abort: abort=1 sampled at an edge in RUN:
  - the write presented that cycle (if web=1) still commits and is counted;
  - web<=0, busy<=0, done<=1, aborted<=1;
  - no further addresses are issued.
  - abort in IDLE or DONE is ignored.
- Address wrap: src+k and dst+k wrap modulo 4096, e.g. src=4094, len=4 reads 4094, 4095, 0, 1.
- Overlap: forward copy only, not memmove.
  - dst=src+d with 0<d<len produces periodic replication of src[0..d-1].
  - d=1 relies on the RAM's write-to-read forwarding on equal addresses; defined behaviour.
  - dst<src overlap copies correctly.
- Reset asserted mid-command: immediate return to the reset values.
  - The write at the asserting edge is not guaranteed.
  - No done pulse.

Decomposition:
- Shared header, dpram_copy.h:
  - state encodings ST_IDLE, ST_RUN, ST_DONE;
  - OP_COPY=0, OP_FILL=1;
  - ADDR_W, DATA_W, LEN_W defaults.
  - Enable/disable levels come from the existing stddef.h.
- One natural sub-module: dpram_copy_agen.
  - Holds the read/write address counters, remaining-count, and terminal-count detect.
  - The FSM and handshake stay in dpram_copy_engine.

Test Plan:
- Copy: RAM[0x100..0x107]=0xA0..0xA7; start op=0, src=0x100, dst=0x200, len=8 -> busy 9 cycles; done at E9; RAM[0x200..0x207]=0xA0..0xA7; count=8.
- Fill: op=1, dst=0xFFE, len=4, fill_data=0xDEADBEEF -> addresses 0xFFE, 0xFFF, 0x000, 0x001 written; wrap verified; count=4.
- Overlap: RAM[0x10]=0x11, RAM[0x11]=0x22; copy src=0x10, dst=0x11, len=4 -> RAM[0x11..0x14] all 0x11.
- Abort: copy len=100; abort at E5 -> done and aborted pulse at E5+; count=4; web low afterwards; RAM[dst+4] unchanged.
- Null/ignore: start with len=0 -> done next cycle, count=0, web never high; second start while busy -> no effect on the running command.
- Reset: reset low at E3 of a len=16 copy -> busy=0, web=0, no done pulse; a new command afterwards completes normally.
